// File: rtl/cnt_wrap_mon_if.sv
// Event stream from the wrap monitor: one {dir, ts} entry per beat,
// transferred when valid and ready are both high.
interface cnt_wrap_mon_if #(
  parameter int TS_W = 16
);
  logic            valid;
  logic            ready;
  logic            dir;
  logic [TS_W-1:0] ts;

  modport master (output valid, output dir, output ts, input ready);
  modport slave  (input valid, input dir, input ts, output ready);
endinterface

// File: rtl/cnt_wrap_mon.sv
// Watches an external up/down counter for natural wrap-arounds, timestamps them
// into a small event FIFO and keeps saturating wrap/drop statistics.
module cnt_wrap_mon #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int TS_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [WIDTH-1:0] count_i,
  input  logic             load_en_i,
  input  logic             down_i,
  cnt_wrap_mon_if.master   evt,
  output logic [7:0]       wrap_up_cnt_o,
  output logic [7:0]       wrap_dn_cnt_o,
  output logic [7:0]       drop_cnt_o
);

  localparam int AW = $clog2(DEPTH);

  // state    | meaning
  // DISARMED | previous sample invalid (en was low or just reset)
  // ARMED    | previous sample valid, wrap detection possible
  typedef enum logic {DISARMED = 1'b0, ARMED = 1'b1} state_e;

  state_e           state_q, state_d;
  logic             armed;
  logic [TS_W-1:0]  ts_q;
  logic [WIDTH-1:0] prev_count_q;
  logic             prev_load_q;
  logic             prev_down_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= DISARMED;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = en_i ? ARMED : DISARMED;
  end

  always_comb begin
    armed = (state_q == ARMED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q         <= '0;
      prev_count_q <= '0;
      prev_load_q  <= 1'b0;
      prev_down_q  <= 1'b0;
    end else begin
      ts_q         <= ts_q + TS_W'(1);
      prev_count_q <= count_i;
      prev_load_q  <= load_en_i;
      prev_down_q  <= down_i;
    end
  end

  // A loaded value that happens to look like a wrap is not an event.
  logic up_wrap, dn_wrap, det;
  always_comb begin
    up_wrap = !prev_down_q && (prev_count_q == '1) && (count_i == '0);
    dn_wrap =  prev_down_q && (prev_count_q == '0) && (count_i == '1);
    det     = armed && en_i && !prev_load_q && (up_wrap || dn_wrap);
  end

  logic [TS_W:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   occ_q, occ_d;
  logic          valid_q;
  logic          full, pop, push, drop;

  always_comb begin
    full  = (occ_q == (AW+1)'(DEPTH));
    pop   = valid_q && evt.ready;
    push  = det && (!full || pop);
    drop  = det && full && !pop;
    occ_d = occ_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  // When full with a simultaneous pop, wr_ptr equals rd_ptr: the head is read
  // this cycle and overwritten at the edge, which is the intended behaviour.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {prev_down_q, ts_q};
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      occ_q   <= occ_d;
      valid_q <= (occ_d != '0);
    end
  end

  assign evt.valid = valid_q;
  assign evt.dir   = mem_q[rd_ptr_q][TS_W];
  assign evt.ts    = mem_q[rd_ptr_q][TS_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_up_cnt_o <= '0;
      wrap_dn_cnt_o <= '0;
      drop_cnt_o    <= '0;
    end else begin
      if (det && up_wrap && wrap_up_cnt_o != 8'hFF) wrap_up_cnt_o <= wrap_up_cnt_o + 8'd1;
      if (det && dn_wrap && wrap_dn_cnt_o != 8'hFF) wrap_dn_cnt_o <= wrap_dn_cnt_o + 8'd1;
      if (drop && drop_cnt_o != 8'hFF)              drop_cnt_o    <= drop_cnt_o + 8'd1;
    end
  end

endmodule

// File: tb/tb_cnt_wrap_mon.sv
// Bench for cnt_wrap_mon: drives a modelled up/down counter and compares the
// monitor against a queue-based event model every cycle.
module tb_cnt_wrap_mon;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [3:0] count = 4'h0;
  logic       load_en = 1'b0;
  logic       down = 1'b0;
  logic [7:0] wrap_up, wrap_dn, drop;

  cnt_wrap_mon_if #(.TS_W(16)) evt_if ();

  cnt_wrap_mon #(.WIDTH(4), .DEPTH(4), .TS_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .en_i          (en),
    .count_i       (count),
    .load_en_i     (load_en),
    .down_i        (down),
    .evt           (evt_if.master),
    .wrap_up_cnt_o (wrap_up),
    .wrap_dn_cnt_o (wrap_dn),
    .drop_cnt_o    (drop)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model
  logic [3:0]  cnt;
  logic [15:0] m_ts;
  bit          m_prev_en, m_prev_ld, m_prev_dn;
  logic [3:0]  m_prev_cnt;
  logic [16:0] m_q[$];
  int          m_up, m_dn, m_drop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_det(input bit e);
    bit is_up, is_dn;
    is_up = !m_prev_dn && m_prev_cnt == 4'hF && cnt == 4'h0;
    is_dn =  m_prev_dn && m_prev_cnt == 4'h0 && cnt == 4'hF;
    return m_prev_en && e && !m_prev_ld && (is_up || is_dn);
  endfunction

  task automatic cycle(input bit e, input bit ld, input logic [3:0] lv,
                       input bit dn, input bit rdy, input bit hold);
    bit det, pop;
    en = e; load_en = ld; down = dn; evt_if.ready = rdy;
    chk("evt_valid", {31'b0, evt_if.valid}, {31'b0, m_q.size() != 0});
    if (m_q.size() != 0) begin
      chk("evt_dir", {31'b0, evt_if.dir}, {31'b0, m_q[0][16]});
      chk("evt_ts", {16'b0, evt_if.ts}, {16'b0, m_q[0][15:0]});
    end
    chk("wrap_up_cnt", {24'b0, wrap_up}, m_up);
    chk("wrap_dn_cnt", {24'b0, wrap_dn}, m_dn);
    chk("drop_cnt", {24'b0, drop}, m_drop);
    det = model_det(e);
    pop = (m_q.size() != 0) && rdy;
    if (pop) void'(m_q.pop_front());
    if (det) begin
      if (m_q.size() < 4) m_q.push_back({m_prev_dn, m_ts});
      else if (m_drop < 255) m_drop++;
      if (m_prev_dn) begin if (m_dn < 255) m_dn++; end
      else           begin if (m_up < 255) m_up++; end
    end
    m_prev_en = e; m_prev_ld = ld; m_prev_dn = dn; m_prev_cnt = cnt;
    m_ts = m_ts + 16'd1;
    if (ld)        cnt = lv;
    else if (!hold) cnt = dn ? cnt - 4'd1 : cnt + 4'd1;
    @(posedge clk); #1;
    count = cnt;
  endtask

  // The counter keeps running through the reset cycle.
  task automatic do_reset();
    rst = 1'b1; load_en = 1'b0;
    cnt = down ? cnt - 4'd1 : cnt + 4'd1;
    @(posedge clk); #1;
    rst = 1'b0;
    count = cnt;
    m_q.delete();
    m_up = 0; m_dn = 0; m_drop = 0; m_ts = '0;
    m_prev_en = 0; m_prev_ld = 0; m_prev_dn = 0; m_prev_cnt = '0;
    chk("rst_valid", {31'b0, evt_if.valid}, 0);
    chk("rst_dir", {31'b0, evt_if.dir}, 0);
    chk("rst_ts", {16'b0, evt_if.ts}, 0);
    chk("rst_up", {24'b0, wrap_up}, 0);
    chk("rst_dn", {24'b0, wrap_dn}, 0);
    chk("rst_drop", {24'b0, drop}, 0);
  endtask

  initial begin
    bit r, dn_r;
    logic [3:0] lv;
    cnt = 4'h0;
    evt_if.ready = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // Up-wrap E -> F -> 0
    cycle(1, 1, 4'hE, 0, 1, 0);
    cycle(1, 0, 4'h0, 0, 1, 0);
    cycle(1, 0, 4'h0, 0, 1, 0);
    cycle(1, 0, 4'h0, 0, 1, 1);
    cycle(1, 0, 4'h0, 0, 1, 1);
    cycle(1, 0, 4'h0, 0, 1, 1);
    chk("req37_up", {24'b0, wrap_up}, 1);

    // Down-wrap 1 -> 0 -> F
    cycle(1, 1, 4'h1, 1, 1, 0);
    cycle(1, 0, 4'h0, 1, 1, 0);
    cycle(1, 0, 4'h0, 1, 1, 0);
    cycle(1, 0, 4'h0, 1, 1, 1);
    cycle(1, 0, 4'h0, 1, 1, 1);
    cycle(1, 0, 4'h0, 1, 1, 1);
    chk("req38_dn", {24'b0, wrap_dn}, 1);
    chk("req38_up", {24'b0, wrap_up}, 1);

    // Load of 0 from F is not a wrap
    cycle(1, 1, 4'hF, 0, 1, 0);
    cycle(1, 0, 4'h0, 0, 1, 1);
    cycle(1, 1, 4'h0, 0, 1, 0);
    cycle(1, 0, 4'h0, 0, 1, 1);
    cycle(1, 0, 4'h0, 0, 1, 1);
    chk("req39_up", {24'b0, wrap_up}, 1);
    chk("req39_valid", {31'b0, evt_if.valid}, 0);

    // Six up-wraps with consumer stalled, then drain
    do_reset();
    cycle(1, 1, 4'h0, 0, 0, 0);
    for (int i = 0; i < 200 && m_up < 6; i++) cycle(1, 0, 4'h0, 0, 0, 0);
    chk("req40_up", {24'b0, wrap_up}, 6);
    chk("req40_drop", {24'b0, drop}, 2);
    for (int i = 0; i < 5; i++) cycle(1, 0, 4'h0, 0, 1, 1);
    chk("req40_empty", {31'b0, evt_if.valid}, 0);

    // Full FIFO, pop in the detection cycle
    do_reset();
    for (int i = 0; i < 200 && m_q.size() < 4; i++) cycle(1, 0, 4'h0, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      r = model_det(1);
      cycle(1, 0, 4'h0, 0, r, 0);
      if (r) break;
    end
    chk("req41_drop", {24'b0, drop}, 0);
    chk("req41_up", {24'b0, wrap_up}, 5);
    cycle(1, 0, 4'h0, 0, 0, 1);

    // Reset with 3 entries held and a wrap about to happen
    do_reset();
    for (int i = 0; i < 200 && m_q.size() < 3; i++) cycle(1, 0, 4'h0, 0, 0, 0);
    for (int i = 0; i < 20 && cnt != 4'hF; i++) cycle(1, 0, 4'h0, 0, 0, 0);
    do_reset();
    cycle(1, 0, 4'h0, 0, 0, 0);
    cycle(1, 0, 4'h0, 0, 0, 0);
    chk("req42_valid", {31'b0, evt_if.valid}, 0);
    chk("req42_up", {24'b0, wrap_up}, 0);

    // Randomized traffic
    dn_r = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) dn_r = ~dn_r;
      case ($urandom_range(0, 2))
        0:       lv = 4'h0;
        1:       lv = 4'hF;
        default: lv = 4'($urandom);
      endcase
      if (i % 500 == 499) do_reset();
      else cycle($urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0, lv,
                 dn_r, $urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
